pipe_stage_buf: RTL and testbench

//   Parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is decoded from registered state only, so back-pressure never forms a combinational path.
module pipe_stage_buf #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 13,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              fwd_valid,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   head_data_r, head_data_s, skid_data_r, skid_data_s;
  logic [CTRL_W-1:0]   head_ctrl_r, head_ctrl_s, skid_ctrl_r, skid_ctrl_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                in_fire_s, out_fire_s, valid_s;

  assign valid_s    = (state_r != EMPTY);
  assign in_ready   = (state_r != FULL);
  assign out_valid  = valid_s;
  assign fwd_valid  = valid_s;
  assign in_fire_s  = in_valid & (state_r != FULL);
  assign out_fire_s = valid_s & out_ready;
  assign stall_cnt  = stall_cnt_r;

  // Next-state and storage update; the skid slot always holds the younger entry.
  always_comb begin
    state_s     = state_r;
    head_data_s = head_data_r;
    head_ctrl_s = head_ctrl_r;
    skid_data_s = skid_data_r;
    skid_ctrl_s = skid_ctrl_r;
    if (flush) begin
      state_s     = EMPTY;
      head_data_s = {DATA_W{1'b0}};
      head_ctrl_s = {CTRL_W{1'b0}};
      skid_data_s = {DATA_W{1'b0}};
      skid_ctrl_s = {CTRL_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s     = ONE;
            head_data_s = in_data;
            head_ctrl_s = in_ctrl;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            head_data_s = in_data;
            head_ctrl_s = in_ctrl;
          end else if (in_fire_s) begin
            state_s     = FULL;
            skid_data_s = in_data;
            skid_ctrl_s = in_ctrl;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_s     = ONE;
            head_data_s = skid_data_r;
            head_ctrl_s = skid_ctrl_r;
          end else begin
            state_s = FULL;
          end
        end
        default: state_s = EMPTY;
      endcase
    end
  end

  // State and entry storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      head_data_r <= {DATA_W{1'b0}};
      head_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
    end else begin
      state_r     <= state_s;
      head_data_r <= head_data_s;
      head_ctrl_r <= head_ctrl_s;
      skid_data_r <= skid_data_s;
      skid_ctrl_r <= skid_ctrl_s;
    end
  end

  // Saturating stall counter; survives flush so stall statistics span redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Head presentation; bubbles optionally forced to zero so they carry no write enables.
  always_comb begin
    out_data = head_data_r;
    out_ctrl = head_ctrl_r;
    if (ZERO_BUBBLE && !valid_s) begin
      out_data = {DATA_W{1'b0}};
      out_ctrl = {CTRL_W{1'b0}};
    end else begin
      out_data = head_data_r;
      out_ctrl = head_ctrl_r;
    end
  end

  // Entry count derived from the state register.
  always_comb begin
    occupancy = 2'd0;
    case (state_r)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: three instances (default, ZERO_BUBBLE=0, CNT_W=4) share stimulus.
// A queue model of held entries predicts every output; a negedge monitor compares.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [12:0] in_ctrl;

  logic        a_in_ready, a_out_valid, a_fwd_valid;
  logic [31:0] a_out_data;
  logic [12:0] a_out_ctrl;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid, b_fwd_valid;
  logic [31:0] b_out_data;
  logic [12:0] b_out_ctrl;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  logic        c_in_ready, c_out_valid, c_fwd_valid;
  logic [31:0] c_out_data;
  logic [12:0] c_out_ctrl;
  logic [1:0]  c_occ;
  logic [3:0]  c_stall;

  pipe_stage_buf dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .fwd_valid(a_fwd_valid),
    .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_buf #(.ZERO_BUBBLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .fwd_valid(b_fwd_valid),
    .occupancy(b_occ), .stall_cnt(b_stall));

  pipe_stage_buf #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_ctrl(c_out_ctrl), .fwd_valid(c_fwd_valid),
    .occupancy(c_occ), .stall_cnt(c_stall));

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [44:0] exp_q[$];
  int          mdl_n   = 0;
  int          s16     = 0;
  int          s4      = 0;
  logic [44:0] last_out = 45'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    mdl_n    = 0;
    s16      = 0;
    s4       = 0;
    last_out = 45'd0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [12:0] c,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = v ? d : 32'hxxxx_xxxx;
    in_ctrl   = v ? c : 13'hxxxx;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of held entries (max two), updated on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        bit fi, fo;
        fi = in_valid && (mdl_n < 2);
        fo = out_ready && (mdl_n > 0);
        if (mdl_n > 0 && !out_ready) begin
          if (s16 < 65535) s16++;
          if (s4 < 15) s4++;
        end
        if (flush) begin
          exp_q.delete();
          mdl_n    = 0;
          last_out = 45'd0;
        end else begin
          if (fi) exp_q.push_back({in_data, in_ctrl});
          mdl_n = mdl_n + int'(fi) - int'(fo);
        end
      end
    end
  end

  // Monitor: compares presented outputs on the falling edge; pops the head when it will fire.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid",   {63'd0, a_out_valid}, {63'd0, mdl_n != 0});
      chk("in_ready",    {63'd0, a_in_ready},  {63'd0, mdl_n < 2});
      chk("fwd_valid",   {63'd0, a_fwd_valid}, {63'd0, mdl_n != 0});
      chk("occupancy",   {62'd0, a_occ},       64'(mdl_n));
      chk("stall_cnt",   {48'd0, a_stall},     64'(s16));
      chk("stall_cnt4",  {60'd0, c_stall},     64'(s4));
      chk("nz_out_valid", {63'd0, b_out_valid}, {63'd0, mdl_n != 0});
      if (mdl_n != 0) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_nonempty", 64'd0, 64'd1);
        end else begin
          chk("out_data", {32'd0, a_out_data}, {32'd0, exp_q[0][44:13]});
          chk("out_ctrl", {51'd0, a_out_ctrl}, {51'd0, exp_q[0][12:0]});
          if (out_ready) begin
            last_out = exp_q[0];
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("bubble_data",  {32'd0, a_out_data}, 64'd0);
        chk("bubble_ctrl",  {51'd0, a_out_ctrl}, 64'd0);
        chk("nz_hold_data", {32'd0, b_out_data}, {32'd0, last_out[44:13]});
        chk("nz_hold_ctrl", {51'd0, b_out_ctrl}, {51'd0, last_out[12:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_ctrl = 13'd0;
    #2;
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, a_in_ready},  64'd1);
    chk("rst_out_data",  {32'd0, a_out_data},  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 13'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);

    // back-pressure: 0xA then 0xB held, then released
    step(1'b1, 32'hA, 13'h0A, 1'b0, 1'b0);
    step(1'b1, 32'hB, 13'h0B, 1'b0, 1'b0);
    repeat (3) step(1'b1, 32'hBAD, 13'h0BD, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);

    // flush with two entries held and 0xC presented
    step(1'b1, 32'h11, 13'h011, 1'b0, 1'b0);
    step(1'b1, 32'h22, 13'h022, 1'b0, 1'b0);
    step(1'b1, 32'hC, 13'h00C, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);

    // bubble: drain an all-ones control word
    step(1'b1, 32'h5, 13'h1FFF, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);

    // saturation of the 4-bit stall counter
    step(1'b1, 32'h7, 13'h007, 1'b0, 1'b0);
    repeat (20) step(1'b0, 32'd0, 13'd0, 1'b0, 1'b0);
    chk("stall4_saturated", {60'd0, c_stall}, 64'd15);
    repeat (2) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);

    // asynchronous reset with two entries held
    step(1'b1, 32'h33, 13'h033, 1'b0, 1'b0);
    step(1'b1, 32'h44, 13'h044, 1'b0, 1'b0);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("midrst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, a_in_ready},  64'd1);
    chk("midrst_occupancy", {62'd0, a_occ},       64'd0);
    chk("midrst_out_ctrl",  {51'd0, a_out_ctrl},  64'd0);
    chk("midrst_stall",     {48'd0, a_stall},     64'd0);
    repeat (2) step(1'b1, 32'h55, 13'h055, 1'b0, 1'b0);
    rst_n = 1'b1;

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 13'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    repeat (3) step(1'b0, 32'd0, 13'd0, 1'b1, 1'b0);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
